seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
- Transmit end of the serial "1101" sync-pattern link; drives the line that the sequence detector watches.
- Accepts a parallel payload word via a valid/ready handshake.
- Serializes each frame as: SYNC_PAT (MSB first), then payload (MSB first), then GAP_BITS idle-level bits so a downstream detector's FSM returns to its idle state.
- One bit is held on the line for BIT_DIV clock cycles.

Parameters:
- DATA_W, 8: payload width in bits, 1..32.
- SYNC_W, 4: sync pattern width in bits, 1..8.
- SYNC_PAT, 4'b1101: sync pattern, sent MSB first.
- BIT_DIV, 1: clock cycles per serial bit, 1..255.
- GAP_BITS, 2: idle-level bits after payload, 0..15; 0 skips GAP.
- IDLE_LEVEL, 1'b0: line level in IDLE and GAP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  payload word, sampled on the accepting edge only.
- data_valid  in  1  payload available.
- data_ready  out  1  block can accept a payload.
- ser_out  out  1  serial line, registered.
- ser_valid  out  1  high while ser_out carries sync or payload bits.
- sync_active  out  1  high while sync bits are on ser_out.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a frame completes.

Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.

Behaviour:
- Reset values (on the first edge with reset=1): state=IDLE, ser_out=IDLE_LEVEL, ser_valid=0, sync_active=0, busy=0, done=0, data_ready=0 while reset is high. Bit and divider counters clear; the shift register clears.
- data_ready = (state==IDLE) && !reset. This is combinational from the state register.
- Accept: data_valid && data_ready sampled at edge k. At that edge:
  - data_in latches into the shift register.
  - State goes to SYNC.
  - ser_out = SYNC_PAT[SYNC_W-1].
  - Latency from acceptance to the first line bit is 0 cycles after edge k.
- Bit timing: the divider counts 0..BIT_DIV-1. The bit advances on the edge where the divider equals BIT_DIV-1. ser_out changes only on bit-advance edges and is stable for exactly BIT_DIV cycles.
- States:
  - SYNC: emits SYNC_PAT bits SYNC_W-1 down to 0. After the last one, goes to DATA with ser_out = data MSB.
  - DATA: emits DATA_W bits MSB first by left shift. After the last one, goes to GAP if GAP_BITS>0, else to IDLE.
  - GAP: ser_out=IDLE_LEVEL and ser_valid=0 for GAP_BITS bit periods, then IDLE.
  - IDLE: ser_out=IDLE_LEVEL.
- Output flags:
  - ser_valid=1 in SYNC and DATA only.
  - sync_active=1 in SYNC only.
  - busy=1 in SYNC, DATA and GAP.
- done: 1 for exactly the first cycle back in IDLE. This is (SYNC_W+DATA_W+GAP_BITS)*BIT_DIV cycles after edge k.
- Back-to-back frames: data_ready is already high in the done cycle. Valid held high is accepted on that edge, giving one IDLE cycle between frames.
- data_in and data_valid changes while busy are ignored. Payload is frozen at acceptance.
- No bit stuffing: a payload containing SYNC_PAT is transmitted verbatim. Framing uniqueness is the system's responsibility.
- Reset mid-frame: on the next edge the state returns to IDLE and all outputs return to reset values. The frame is discarded and no done pulse is produced.
- Reset and data_valid together: reset wins and nothing is accepted.
- Illegal parameter values are rejected by an elaboration-time check.

Decomposition:
- Package seq_pattern_pkg holds:
  - the TX state encodings (TX_IDLE, TX_SYNC, TX_DATA, TX_GAP as 2-bit constants);
  - the default sync pattern constant SYNC_1101 = 4'b1101 and its width;
  - a helper constant for the frame length in bits.
- One sub-module, bit_tick_gen: a parameterized BIT_DIV divider with clear input, emitting a one-cycle bit-advance strobe.
- The FSM, shift register and bit counter stay in seq_pattern_tx.

Test Plan:
1. Single frame, defaults, data_in=8'hA5 accepted at edge k.
   - ser_out over cycles k..k+13 = 1,1,0,1, 1,0,1,0,0,1,0,1, 0,0.
   - ser_valid=1 for cycles 0..11 after k; sync_active=1 for cycles 0..3.
   - done=1 at cycle 14 only.
2. Loopback: connect ser_out to the detector's input and send 8'h00.
   - Mealy output pulses once, during the 4th sync bit.
   - Moore output is high for one cycle after it.
   - No further detections occur through the gap.
3. BIT_DIV=3, data_in=8'hFF.
   - Every bit is held exactly 3 cycles.
   - Frame length is 42 cycles; done=1 at cycle 42.
4. data_valid held high with two words, 8'h0F then 8'hF0.
   - Second acceptance happens on the done cycle.
   - Exactly one IDLE cycle separates the frames.
   - data_in changes during frame 1 do not appear on ser_out.
5. Reset asserted during DATA bit 3, held 1 cycle.
   - Next cycle: ser_out=0, ser_valid=0, busy=0, data_ready=1.
   - No done pulse.
   - A new frame starts cleanly afterwards.
6. GAP_BITS=0, data_in=8'h81.
   - ser_out goes directly from the payload LSB (1) to IDLE.
   - done at cycle 12.

Source files
------------

// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the "1101" sync-pattern transmitter.
// Contents:
//   tx_state_e          - TX FSM state encodings (2 bits)
//   SYNC_1101/_W        - default sync pattern and its width
//   DEFAULT_*           - default payload width and gap length
//   frame_bits()        - bits per frame (sync + payload + gap)
//   FRAME_BITS_DEFAULT  - frame length in bits for the default configuration
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SYNC = 2'd1,
    TX_DATA = 2'd2,
    TX_GAP  = 2'd3
  } tx_state_e;

  localparam int unsigned SYNC_1101_W = 4;
  localparam logic [SYNC_1101_W-1:0] SYNC_1101 = 4'b1101;

  localparam int unsigned DEFAULT_DATA_W   = 8;
  localparam int unsigned DEFAULT_GAP_BITS = 2;

  function automatic int unsigned frame_bits(input int unsigned sync_w,
                                             input int unsigned data_w,
                                             input int unsigned gap_bits);
    return sync_w + data_w + gap_bits;
  endfunction

  localparam int unsigned FRAME_BITS_DEFAULT =
    frame_bits(SYNC_1101_W, DEFAULT_DATA_W, DEFAULT_GAP_BITS);

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Payload handshake and serial line bundle of seq_pattern_tx.
// Signals:
//   data_in     payload word (DATA_W bits)
//   data_valid  payload available
//   data_ready  transmitter can accept a payload
//   ser_out     serial line
//   ser_valid   ser_out carries sync or payload bits
//   sync_active sync bits are on ser_out
//   busy        a frame is in progress
//   done        one-cycle pulse at frame completion
// Modports: master = payload source / line observer, slave = transmitter.
interface seq_pattern_tx_if
  import seq_pattern_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              sync_active;
  logic              busy;
  logic              done;

  modport master (
    output data_in, data_valid,
    input  data_ready, ser_out, ser_valid, sync_active, busy, done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, ser_out, ser_valid, sync_active, busy, done
  );

endinterface

// File: rtl/seq_pattern_tx_bit_tick_gen.sv
// Bit-period divider: counts 0..BIT_DIV-1 and strobes o_tick while the
// count sits at BIT_DIV-1, i.e. on the edge where the serial bit advances.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   i_clear  hold the count at zero (used while the transmitter is idle)
//   o_tick   bit-advance strobe (constantly high when BIT_DIV == 1)
module bit_tick_gen #(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Divider count: wraps at the last cycle of a bit, held at zero on clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/seq_pattern_tx.sv
// Transmit end of the "1101" sync-pattern serial link.
// Accepts a payload word on a valid/ready handshake and sends
// SYNC_PAT (MSB first), the payload (MSB first), then GAP_BITS idle-level
// bits, each bit held for BIT_DIV clocks.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    seq_pattern_tx_if.slave: data_in/data_valid in; data_ready,
//          ser_out, ser_valid, sync_active, busy, done out
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int unsigned     DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned     SYNC_W     = SYNC_1101_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_1101,
  parameter int unsigned     BIT_DIV    = 1,
  parameter int unsigned     GAP_BITS   = DEFAULT_GAP_BITS,
  parameter logic            IDLE_LEVEL = 1'b0
) (
  input logic           clk,
  input logic           reset,
  seq_pattern_tx_if.slave bus
);

  if ((DATA_W < 1) || (DATA_W > 32) || (SYNC_W < 1) || (SYNC_W > 8) ||
      (BIT_DIV < 1) || (BIT_DIV > 255) || (GAP_BITS > 15)) begin : g_bad_param
    $error("seq_pattern_tx: illegal parameter value");
  end

  localparam int unsigned BCNT_W = 6;
  localparam logic [BCNT_W-1:0] SYNC_LAST = BCNT_W'(SYNC_W - 1);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_W - 1);
  localparam logic [BCNT_W-1:0] GAP_LAST  = BCNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  tx_state_e         r_state;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_sync_active;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_shift;
  logic [SYNC_W-1:0] r_sync_sh;
  logic [BCNT_W-1:0] r_bit_cnt;

  tx_state_e         w_state_nxt;
  logic              w_ser_nxt;
  logic              w_done_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [SYNC_W-1:0] w_sync_nxt;
  logic [BCNT_W-1:0] w_bit_nxt;
  logic              w_tick;

  bit_tick_gen #(
    .BIT_DIV (BIT_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state == TX_IDLE),
    .o_tick  (w_tick)
  );

  // Next-state and next-line-bit logic. Both shift registers always hold the
  // bit to send next in their MSB, so entering a state loads ser_out from the
  // MSB and shifts once; the line bit is therefore valid in the accept cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ser_nxt   = r_ser_out;
    w_shift_nxt = r_shift;
    w_sync_nxt  = r_sync_sh;
    w_bit_nxt   = r_bit_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_ser_nxt = IDLE_LEVEL;
        if (bus.data_valid) begin
          w_state_nxt = TX_SYNC;
          w_ser_nxt   = SYNC_PAT[SYNC_W-1];
          w_sync_nxt  = SYNC_PAT << 1;
          w_shift_nxt = bus.data_in;
          w_bit_nxt   = '0;
        end else begin
          w_state_nxt = TX_IDLE;
        end
      end
      TX_SYNC: begin
        if (w_tick) begin
          if (r_bit_cnt == SYNC_LAST) begin
            w_state_nxt = TX_DATA;
            w_ser_nxt   = r_shift[DATA_W-1];
            w_shift_nxt = r_shift << 1;
            w_bit_nxt   = '0;
          end else begin
            w_ser_nxt  = r_sync_sh[SYNC_W-1];
            w_sync_nxt = r_sync_sh << 1;
            w_bit_nxt  = r_bit_cnt + 6'd1;
          end
        end else begin
          w_state_nxt = TX_SYNC;
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == DATA_LAST) begin
            w_ser_nxt = IDLE_LEVEL;
            w_bit_nxt = '0;
            if (GAP_BITS > 0) begin
              w_state_nxt = TX_GAP;
            end else begin
              w_state_nxt = TX_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_ser_nxt   = r_shift[DATA_W-1];
            w_shift_nxt = r_shift << 1;
            w_bit_nxt   = r_bit_cnt + 6'd1;
          end
        end else begin
          w_state_nxt = TX_DATA;
        end
      end
      TX_GAP: begin
        w_ser_nxt = IDLE_LEVEL;
        if (w_tick) begin
          if (r_bit_cnt == GAP_LAST) begin
            w_state_nxt = TX_IDLE;
            w_done_nxt  = 1'b1;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit_cnt + 6'd1;
          end
        end else begin
          w_state_nxt = TX_GAP;
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_ser_nxt   = IDLE_LEVEL;
      end
    endcase
  end

  // State, datapath and registered status flags (flags follow the next state
  // so they line up with the bit being driven onto ser_out).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= TX_IDLE;
      r_ser_out     <= IDLE_LEVEL;
      r_ser_valid   <= 1'b0;
      r_sync_active <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_shift       <= '0;
      r_sync_sh     <= '0;
      r_bit_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ser_out     <= w_ser_nxt;
      r_ser_valid   <= (w_state_nxt == TX_SYNC) || (w_state_nxt == TX_DATA);
      r_sync_active <= (w_state_nxt == TX_SYNC);
      r_busy        <= (w_state_nxt != TX_IDLE);
      r_done        <= w_done_nxt;
      r_shift       <= w_shift_nxt;
      r_sync_sh     <= w_sync_nxt;
      r_bit_cnt     <= w_bit_nxt;
    end
  end

  assign bus.data_ready  = (r_state == TX_IDLE) && !reset;
  assign bus.ser_out     = r_ser_out;
  assign bus.ser_valid   = r_ser_valid;
  assign bus.sync_active = r_sync_active;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: three instances (default,
// BIT_DIV=3, GAP_BITS=0), a per-cycle expected-output queue built from a
// frame model, and a 1101 Mealy/Moore detector looped back on instance 0.
module tb_seq_pattern_tx;
  import seq_pattern_pkg::*;

  typedef struct packed {
    logic ser;
    logic vld;
    logic syn;
    logic bsy;
    logic dne;
    logic rdy;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  int         sel;
  logic       tb_valid;
  logic [7:0] tb_data;
  obs_t       obs;
  obs_t       exp_q[$];

  int n_asserts = 0;
  int n_fail    = 0;
  int mealy_cnt, mealy_at, moore_cnt, moore_at, done_at;
  logic [15:0] ser_hist;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.DATA_W(8)) if0 ();
  seq_pattern_tx_if #(.DATA_W(8)) if1 ();
  seq_pattern_tx_if #(.DATA_W(8)) if2 ();

  assign if0.data_valid = tb_valid && (sel == 0);
  assign if1.data_valid = tb_valid && (sel == 1);
  assign if2.data_valid = tb_valid && (sel == 2);
  assign if0.data_in = tb_data;
  assign if1.data_in = tb_data;
  assign if2.data_in = tb_data;

  seq_pattern_tx #(.BIT_DIV(1), .GAP_BITS(2)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  seq_pattern_tx #(.BIT_DIV(3), .GAP_BITS(2)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  seq_pattern_tx #(.BIT_DIV(1), .GAP_BITS(0)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  // Observation mux onto the instance under test.
  always_comb begin
    case (sel)
      1:       obs = {if1.ser_out, if1.ser_valid, if1.sync_active, if1.busy, if1.done, if1.data_ready};
      2:       obs = {if2.ser_out, if2.ser_valid, if2.sync_active, if2.busy, if2.done, if2.data_ready};
      default: obs = {if0.ser_out, if0.ser_valid, if0.sync_active, if0.busy, if0.done, if0.data_ready};
    endcase
  end

  // Overlapping 1101 detector listening on instance 0's line.
  logic [1:0] det_st;
  logic       det_moore;
  logic       det_mealy;
  assign det_mealy = (det_st == 2'd3) && if0.ser_out;
  always_ff @(posedge clk) begin
    if (reset) begin
      det_st    <= 2'd0;
      det_moore <= 1'b0;
    end else begin
      det_moore <= det_mealy;
      case (det_st)
        2'd0:    det_st <= if0.ser_out ? 2'd1 : 2'd0;
        2'd1:    det_st <= if0.ser_out ? 2'd2 : 2'd0;
        2'd2:    det_st <= if0.ser_out ? 2'd2 : 2'd3;
        default: det_st <= if0.ser_out ? 2'd1 : 2'd0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Expected outputs for cycle offsets 0..L after the accepting edge.
  task automatic push_frame(input logic [7:0] d, input int div, input int gap);
    logic [3:0] pat;
    int L;
    int b;
    obs_t e;
    pat = 4'b1101;
    L = int'(frame_bits(4, 8, gap)) * div;
    for (int off = 0; off <= L; off++) begin
      b = off / div;
      if (off == L)      e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      else if (b < 4)    e = {pat[3-b], 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      else if (b < 12)   e = {d[11-b], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      else               e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_q.push_back(e);
    end
  endtask

  task automatic check_entry(input string tag, input int c);
    obs_t e;
    e = exp_q.pop_front();
    chk($sformatf("%s[%0d].ser_out", tag, c),     32'(obs.ser), 32'(e.ser));
    chk($sformatf("%s[%0d].ser_valid", tag, c),   32'(obs.vld), 32'(e.vld));
    chk($sformatf("%s[%0d].sync_active", tag, c), 32'(obs.syn), 32'(e.syn));
    chk($sformatf("%s[%0d].busy", tag, c),        32'(obs.bsy), 32'(e.bsy));
    chk($sformatf("%s[%0d].done", tag, c),        32'(obs.dne), 32'(e.dne));
    chk($sformatf("%s[%0d].data_ready", tag, c),  32'(obs.rdy), 32'(e.rdy));
  endtask

  // One frame (or two back-to-back with valid held high), checked per cycle.
  task automatic run_frames(input string tag, input int s, input logic [7:0] d0,
                            input logic [7:0] d1, input bit two, input int div, input int gap);
    int L;
    int n;
    L = int'(frame_bits(4, 8, gap)) * div;
    @(negedge clk);
    sel = s;
    tb_data = d0;
    tb_valid = 1'b1;
    chk({tag, ".ready_before"}, 32'(obs.rdy), 32'd1);
    exp_q.delete();
    push_frame(d0, div, gap);
    if (two) push_frame(d1, div, gap);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    n = exp_q.size();
    mealy_cnt = 0; mealy_at = -1; moore_cnt = 0; moore_at = -1; done_at = -1;
    ser_hist = '0;
    @(posedge clk);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_entry(tag, c);
      ser_hist = {ser_hist[14:0], obs.ser};
      if (det_mealy) begin mealy_cnt++; if (mealy_at < 0) mealy_at = c; end
      if (det_moore) begin moore_cnt++; if (moore_at < 0) moore_at = c; end
      if (obs.dne && (done_at < 0)) done_at = c;
      if (two) begin
        tb_valid = (c <= L);
        tb_data  = ((c >= L - 3) && (c <= L)) ? d1 : 8'($urandom);
      end else begin
        tb_valid = (c[0] == 1'b1) && (c < L - 2);
        tb_data  = 8'($urandom);
      end
    end
    tb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tb_valid = 1'b0;
    tb_data = 8'h00;
    sel = 0;
    repeat (3) @(negedge clk);
    chk("rst.ser_out", 32'(obs.ser), 32'd0);
    chk("rst.ser_valid", 32'(obs.vld), 32'd0);
    chk("rst.sync_active", 32'(obs.syn), 32'd0);
    chk("rst.busy", 32'(obs.bsy), 32'd0);
    chk("rst.done", 32'(obs.dne), 32'd0);
    chk("rst.data_ready", 32'(obs.rdy), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.ready_after", 32'(obs.rdy), 32'd1);

    // 1: default frame, A5
    run_frames("t1", 0, 8'hA5, 8'h00, 1'b0, 1, 2);
    chk("t1.ser_seq", 32'(ser_hist), 32'h0000_DA50);
    chk("t1.done_at", 32'(done_at), 32'(FRAME_BITS_DEFAULT));

    // 2: loopback into the detector, payload 00
    run_frames("t2", 0, 8'h00, 8'h00, 1'b0, 1, 2);
    chk("t2.mealy_cnt", 32'(mealy_cnt), 32'd1);
    chk("t2.mealy_at", 32'(mealy_at), 32'd3);
    chk("t2.moore_cnt", 32'(moore_cnt), 32'd1);
    chk("t2.moore_at", 32'(moore_at), 32'd4);

    // 3: BIT_DIV=3, FF
    run_frames("t3", 1, 8'hFF, 8'h00, 1'b0, 3, 2);
    chk("t3.done_at", 32'(done_at), 32'd42);

    // 4: back-to-back 0F then F0, valid held high
    run_frames("t4", 0, 8'h0F, 8'hF0, 1'b1, 1, 2);
    chk("t4.done_at", 32'(done_at), 32'd14);

    // 5: reset during DATA bit 3
    @(negedge clk);
    sel = 0;
    tb_data = 8'h5A;
    tb_valid = 1'b1;
    exp_q.delete();
    push_frame(8'h5A, 1, 2);
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_entry("t5", c);
      tb_valid = 1'b0;
      tb_data = 8'($urandom);
      if (c == 7) reset = 1'b1;
    end
    exp_q.delete();
    @(negedge clk);
    chk("t5.rst_ser_out", 32'(obs.ser), 32'd0);
    chk("t5.rst_ser_valid", 32'(obs.vld), 32'd0);
    chk("t5.rst_sync_active", 32'(obs.syn), 32'd0);
    chk("t5.rst_busy", 32'(obs.bsy), 32'd0);
    chk("t5.rst_done", 32'(obs.dne), 32'd0);
    chk("t5.rst_ready_in_reset", 32'(obs.rdy), 32'd0);
    reset = 1'b0;
    #1;
    chk("t5.ready_after", 32'(obs.rdy), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("t5.quiet[%0d].done", c), 32'(obs.dne), 32'd0);
      chk($sformatf("t5.quiet[%0d].busy", c), 32'(obs.bsy), 32'd0);
    end
    run_frames("t5b", 0, 8'h3C, 8'h00, 1'b0, 1, 2);

    // reset together with data_valid: nothing accepted
    @(negedge clk);
    reset = 1'b1;
    tb_valid = 1'b1;
    tb_data = 8'hC3;
    @(negedge clk);
    chk("rv.busy", 32'(obs.bsy), 32'd0);
    chk("rv.ser_valid", 32'(obs.vld), 32'd0);
    reset = 1'b0;
    tb_valid = 1'b0;
    @(negedge clk);
    chk("rv.busy_after", 32'(obs.bsy), 32'd0);

    // 6: GAP_BITS=0, 81
    run_frames("t6", 2, 8'h81, 8'h00, 1'b0, 1, 0);
    chk("t6.done_at", 32'(done_at), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
